// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: issues PC redirect + latch flushes on a taken EX branch,
// then squashes wrong-path outcomes for a shadow window. Optional stats via BRANCH_STATS_EN.
module branch_redirect_ctrl #(
    parameter int PC_WIDTH      = 32,
    parameter int SHADOW_CYCLES = 2,
    parameter int STAT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EX_valid,
    input  logic                  EX_is_branch,
    input  logic                  EX_is_Branch_Taken,
    input  logic [PC_WIDTH-1:0]   EX_branchPC,
    input  logic                  stall_in,
    output logic                  pc_redirect,
    output logic [PC_WIDTH-1:0]   redirect_PC,
    output logic                  flush_IF_OF,
    output logic                  flush_OF_EX,
    output logic                  squash_active,
    output logic [1:0]            ctrl_state,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_taken,
    output logic [STAT_WIDTH-1:0] stat_squashed
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SHADOW   = 2'd2,
        ILLEGAL  = 2'd3
    } ctrlState_e;

    localparam int CNT_W = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SHADOW_LOAD =
        (SHADOW_CYCLES > 0) ? CNT_W'(SHADOW_CYCLES - 1) : '0;

    ctrlState_e           state, nextState;
    logic [CNT_W-1:0]     shadowCnt, nextCnt;
    logic [PC_WIDTH-1:0]  redirectPc;
    logic                 redirectQ, squashQ;
    logic                 accept;

    // Only IDLE can accept; anything seen while busy is wrong-path.
    assign accept = (state == IDLE) && EX_valid && EX_is_Branch_Taken;

    always_comb begin
        nextState = state;
        nextCnt   = shadowCnt;
        case (state)
            IDLE:     if (accept) nextState = REDIRECT;
            REDIRECT: if (!stall_in) begin
                if (SHADOW_CYCLES == 0) begin
                    nextState = IDLE;
                end else begin
                    nextState = SHADOW;
                    nextCnt   = SHADOW_LOAD;
                end
            end
            SHADOW:   if (!stall_in) begin
                if (shadowCnt == '0) nextState = IDLE;
                else                 nextCnt   = shadowCnt - CNT_W'(1);
            end
            default:  nextState = IDLE;
        endcase
    end

    // Output flags are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shadowCnt  <= '0;
            redirectPc <= '0;
            redirectQ  <= 1'b0;
            squashQ    <= 1'b0;
        end else begin
            state      <= nextState;
            shadowCnt  <= nextCnt;
            if (accept) redirectPc <= EX_branchPC;
            redirectQ  <= (nextState == REDIRECT);
            squashQ    <= (nextState == REDIRECT) || (nextState == SHADOW);
        end
    end

    assign pc_redirect   = redirectQ;
    assign flush_IF_OF   = redirectQ;
    assign flush_OF_EX   = redirectQ;
    assign squash_active = squashQ;
    assign redirect_PC   = redirectPc;
    assign ctrl_state    = state;

`ifdef BRANCH_STATS_EN
    logic [STAT_WIDTH-1:0] nBranches, nTaken, nSquashed;
    logic                  busy;

    assign busy = (state == REDIRECT) || (state == SHADOW);

    // Saturating counters: stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            nBranches <= '0;
            nTaken    <= '0;
            nSquashed <= '0;
        end else begin
            if ((state == IDLE) && EX_valid && EX_is_branch && (nBranches != '1))
                nBranches <= nBranches + STAT_WIDTH'(1);
            if (accept && (nTaken != '1))
                nTaken <= nTaken + STAT_WIDTH'(1);
            if (busy && EX_valid && EX_is_Branch_Taken && (nSquashed != '1))
                nSquashed <= nSquashed + STAT_WIDTH'(1);
        end
    end

    assign stat_branches = nBranches;
    assign stat_taken    = nTaken;
    assign stat_squashed = nSquashed;
`else
    logic unusedIsBranch;
    assign unusedIsBranch = EX_is_branch;
    assign stat_branches  = '0;
    assign stat_taken     = '0;
    assign stat_squashed  = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (SHADOW_CYCLES=2/STAT_WIDTH=16 and
// SHADOW_CYCLES=0/STAT_WIDTH=4) driven in lockstep and compared to a squash-budget model.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset, EX_valid, EX_is_branch, EX_is_Branch_Taken, stall_in;
    logic [31:0] EX_branchPC;

    logic        aRedir, aF1, aF2, aSq;
    logic [31:0] aPc;
    logic [1:0]  aSt;
    logic [15:0] aSb, aStk, aSsq;

    logic        bRedir, bF1, bF2, bSq;
    logic [31:0] bPc;
    logic [1:0]  bSt;
    logic [3:0]  bSb, bStk, bSsq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.PC_WIDTH(32), .SHADOW_CYCLES(2), .STAT_WIDTH(16)) dutA (
        .clk(clk), .reset(reset), .EX_valid(EX_valid), .EX_is_branch(EX_is_branch),
        .EX_is_Branch_Taken(EX_is_Branch_Taken), .EX_branchPC(EX_branchPC), .stall_in(stall_in),
        .pc_redirect(aRedir), .redirect_PC(aPc), .flush_IF_OF(aF1), .flush_OF_EX(aF2),
        .squash_active(aSq), .ctrl_state(aSt),
        .stat_branches(aSb), .stat_taken(aStk), .stat_squashed(aSsq)
    );

    branch_redirect_ctrl #(.PC_WIDTH(32), .SHADOW_CYCLES(0), .STAT_WIDTH(4)) dutB (
        .clk(clk), .reset(reset), .EX_valid(EX_valid), .EX_is_branch(EX_is_branch),
        .EX_is_Branch_Taken(EX_is_Branch_Taken), .EX_branchPC(EX_branchPC), .stall_in(stall_in),
        .pc_redirect(bRedir), .redirect_PC(bPc), .flush_IF_OF(bF1), .flush_OF_EX(bF2),
        .squash_active(bSq), .ctrl_state(bSt),
        .stat_branches(bSb), .stat_taken(bStk), .stat_squashed(bSsq)
    );

    // Model: a squash budget of SHADOW+1 non-stalled cycles opens on each accept.
    // First budget cycle is the redirect; the remainder is the shadow.
    int          shadow [2] = '{2, 0};
    int          statMax[2] = '{65535, 15};
    int          budget [2];
    logic [31:0] mPc    [2];
    int          mBr[2], mTk[2], mSq[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int satInc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                budget[i] = 0; mPc[i] = '0; mBr[i] = 0; mTk[i] = 0; mSq[i] = 0;
            end else if (budget[i] == 0) begin
                if (EX_valid && EX_is_branch) mBr[i] = satInc(mBr[i], statMax[i]);
                if (EX_valid && EX_is_Branch_Taken) begin
                    budget[i] = shadow[i] + 1;
                    mPc[i]    = EX_branchPC;
                    mTk[i]    = satInc(mTk[i], statMax[i]);
                end
            end else begin
                if (EX_valid && EX_is_Branch_Taken) mSq[i] = satInc(mSq[i], statMax[i]);
                if (!stall_in) budget[i]--;
            end
        end
    endtask

    task automatic checkInst(input int i, input string nm, input logic redir, input logic [31:0] rpc,
                             input logic f1, input logic f2, input logic sq, input logic [1:0] st,
                             input logic [15:0] sb, input logic [15:0] stk, input logic [15:0] ssq);
        logic inRedir;
        int   expSt;
        inRedir = (budget[i] == shadow[i] + 1);
        expSt   = (budget[i] == 0) ? 0 : (inRedir ? 1 : 2);
        chk({nm, ".state"},    64'(st),    64'(expSt));
        chk({nm, ".redirect"}, 64'(redir), 64'(inRedir));
        chk({nm, ".flushIF"},  64'(f1),    64'(inRedir));
        chk({nm, ".flushOF"},  64'(f2),    64'(inRedir));
        chk({nm, ".squash"},   64'(sq),    64'(budget[i] != 0));
        chk({nm, ".pc"},       64'(rpc),   64'(mPc[i]));
`ifdef BRANCH_STATS_EN
        chk({nm, ".statBr"},   64'(sb),  64'(mBr[i]));
        chk({nm, ".statTk"},   64'(stk), 64'(mTk[i]));
        chk({nm, ".statSq"},   64'(ssq), 64'(mSq[i]));
`else
        chk({nm, ".statBr"},   64'(sb),  64'd0);
        chk({nm, ".statTk"},   64'(stk), 64'd0);
        chk({nm, ".statSq"},   64'(ssq), 64'd0);
`endif
    endtask

    task automatic cycle(input logic v, input logic br, input logic tk, input logic [31:0] pc,
                         input logic st, input logic rst);
        EX_valid = v; EX_is_branch = br; EX_is_Branch_Taken = tk;
        EX_branchPC = pc; stall_in = st; reset = rst;
        @(posedge clk);
        modelEdge();
        #1;
        checkInst(0, "A", aRedir, aPc, aF1, aF2, aSq, aSt, aSb, aStk, aSsq);
        checkInst(1, "B", bRedir, bPc, bF1, bF2, bSq, bSt, 16'(bSb), 16'(bStk), 16'(bSsq));
    endtask

    task automatic idle(input logic st);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, st, 1'b0);
    endtask

    task automatic take(input logic [31:0] pc);
        cycle(1'b1, 1'b1, 1'b1, pc, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst.state", 64'(aSt), 64'd0);
        chk("rst.pc",    64'(aPc), 64'd0);
        chk("rst.redir", 64'(aRedir), 64'd0);

        // Basic accept: states 1,2,2,0
        take(32'h40);
        chk("t1.state0", 64'(aSt), 64'd1);
        chk("t1.pc",     64'(aPc), 64'h40);
        chk("t1.redir",  64'(aRedir), 64'd1);
        idle(1'b0); chk("t1.state1", 64'(aSt), 64'd2); chk("t1.redirOff", 64'(aRedir), 64'd0);
        idle(1'b0); chk("t1.state2", 64'(aSt), 64'd2); chk("t1.sqOn", 64'(aSq), 64'd1);
        idle(1'b0); chk("t1.state3", 64'(aSt), 64'd0); chk("t1.sqOff", 64'(aSq), 64'd0);

        // Stalled redirect held 4 cycles, then shadow extended by 2 stalls
        take(32'h100);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1); chk("t2.redirHold", 64'(aRedir), 64'd1);
        end
        idle(1'b0); chk("t2.shadow", 64'(aSt), 64'd2);
        idle(1'b1); idle(1'b1); chk("t2.stallShadow", 64'(aSq), 64'd1);
        idle(1'b0); chk("t2.shadowLast", 64'(aSt), 64'd2);
        idle(1'b0); chk("t2.idle", 64'(aSt), 64'd0);

        // Wrong-path taken branch every cycle after an accept
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        take(32'h40);
        for (int k = 0; k < 3; k++) begin
            take(32'h200); chk("t3.pcHeld", 64'(aPc), 64'h40);
        end
        take(32'h200);
        chk("t3.accept200", 64'(aPc), 64'h200);
        chk("t3.state", 64'(aSt), 64'd1);
`ifdef BRANCH_STATS_EN
        chk("t3.squashed", 64'(aSsq), 64'd3);
`endif

        // Reset during shadow abandons the sequence
        idle(1'b0);
        chk("t4.inShadow", 64'(aSt), 64'd2);
        cycle(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
        chk("t4.state", 64'(aSt), 64'd0);
        chk("t4.pc",    64'(aPc), 64'd0);
        chk("t4.sq",    64'(aSq), 64'd0);
        idle(1'b0); chk("t4.noRedir", 64'(aRedir), 64'd0);

        // SHADOW_CYCLES=0 instance: back-to-back 0x10, 0x20, 0x30
        take(32'h10); chk("t5.s0", 64'(bSt), 64'd1); chk("t5.pc0", 64'(bPc), 64'h10);
        take(32'h20); chk("t5.s1", 64'(bSt), 64'd0); chk("t5.pc1", 64'(bPc), 64'h10);
        take(32'h30); chk("t5.s2", 64'(bSt), 64'd1); chk("t5.pc2", 64'(bPc), 64'h30);

        // 20 accepts on the 4-bit stats instance
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            take(32'h1000 + 32'(k)); idle(1'b0);
        end
`ifdef BRANCH_STATS_EN
        chk("t6.statSat", 64'(bStk), 64'hF);
`else
        chk("t6.statZero", 64'(bStk), 64'd0);
`endif

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            logic v, tk;
            v  = ($urandom_range(0, 3) != 0);
            tk = ($urandom_range(0, 1) != 0);
            cycle(v, tk | ($urandom_range(0, 3) == 0), tk, $urandom,
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
